// File: rtl/npc_pipe_pkg.sv
// ============================================================================
// npc_pipe_pkg : shared types for the NPC five-stage pipeline control path
// Rev 1.0
// ============================================================================
`default_nettype none

package npc_pipe_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MDU_HOLD = 2'd2
  } hz_state_e;

  // Per-stage register controls, consumed directly by the stage registers
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_ls_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_ls_bubble;
    logic ls_wb_bubble;
  } pipe_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// hazard_detect : load-use comparator between the ID and EX slots
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_detect
  import npc_pipe_pkg::*;
(
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic                 ex_we,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_ex_load_wr;

  // x0 is hardwired, so a load targeting it never creates a dependency
  assign w_ex_load_wr = ex_valid & ex_is_load & ex_we & (ex_rd != '0);
  assign w_rs1_hit    = id_rs1_used & (id_rs1 == ex_rd);
  assign w_rs2_hit    = id_rs2_used & (id_rs2 == ex_rd);
  assign load_use     = id_valid & w_ex_load_wr & (w_rs1_hit | w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall/flush/redirect scheduler for the NPC pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import npc_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 id_valid,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic                 ex_we,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_redirect,
  input  logic [WIDTH-1:0]     ex_redirect_pc,
  input  logic                 ex_mdu_start,
  input  logic                 ex_mdu_done,
  input  logic                 ls_mem_req,
  input  logic                 ls_mem_ready,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_ex_stall,
  output logic                 ex_ls_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_ls_bubble,
  output logic                 ls_wb_bubble,
  output logic                 pc_redirect_valid,
  output logic [WIDTH-1:0]     pc_redirect_target,
  output logic                 mem_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  hz_state_e        state_q, state_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic             w_freeze;
  logic             w_load_use;
  logic             w_mdu_stall;
  pipe_ctrl_t       w_ctrl;
  logic             w_rdr_valid;
  logic [WIDTH-1:0] w_rdr_target;

  assign w_freeze = ls_mem_req & ~ls_mem_ready;

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_we       (ex_we),
    .ex_rd       (ex_rd),
    .load_use    (w_load_use)
  );

  // The start cycle stalls too, before the state register has moved
  assign w_mdu_stall = ((state_q == ST_MDU_WAIT) & ~ex_mdu_done) |
                       ((state_q == ST_RUN) & ex_mdu_start);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (ex_mdu_start) state_d = ST_MDU_WAIT;
      ST_MDU_WAIT: if (ex_mdu_done)  state_d = w_freeze ? ST_MDU_HOLD : ST_RUN;
      ST_MDU_HOLD: if (!w_freeze)    state_d = ST_RUN;
      default:                       state_d = ST_RUN;
    endcase
  end

  always_comb begin
    w_ctrl       = '0;
    w_rdr_valid  = 1'b0;
    w_rdr_target = '0;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;

    if (w_freeze) begin
      w_ctrl.pc_stall     = 1'b1;
      w_ctrl.if_id_stall  = 1'b1;
      w_ctrl.id_ex_stall  = 1'b1;
      w_ctrl.ex_ls_stall  = 1'b1;
      w_ctrl.ls_wb_bubble = 1'b1;
      if (ex_redirect) begin
        pend_d    = 1'b1;
        pend_pc_d = ex_redirect_pc;
      end
    end else if (w_mdu_stall) begin
      w_ctrl.pc_stall     = 1'b1;
      w_ctrl.if_id_stall  = 1'b1;
      w_ctrl.id_ex_stall  = 1'b1;
      w_ctrl.ex_ls_bubble = 1'b1;
    end else if (ex_redirect | pend_q) begin
      w_ctrl.if_id_flush = 1'b1;
      w_ctrl.id_ex_flush = 1'b1;
      w_rdr_valid        = 1'b1;
      w_rdr_target       = ex_redirect ? ex_redirect_pc : pend_pc_q;
      pend_d             = 1'b0;
    end else if (w_load_use) begin
      w_ctrl.pc_stall    = 1'b1;
      w_ctrl.if_id_stall = 1'b1;
      w_ctrl.id_ex_flush = 1'b1;
    end

    // Outputs are silenced for the whole reset window, not just at the edge
    if (!rst_n) begin
      w_ctrl       = '0;
      w_rdr_valid  = 1'b0;
      w_rdr_target = '0;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (w_freeze) begin
      wait_cnt_d = (wait_cnt_q == CNT_W'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    mem_timeout_d = mem_timeout_q | (w_freeze & (wait_cnt_q == CNT_W'(TIMEOUT - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pend_q        <= 1'b0;
      pend_pc_q     <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_stall           = w_ctrl.pc_stall;
  assign if_id_stall        = w_ctrl.if_id_stall;
  assign id_ex_stall        = w_ctrl.id_ex_stall;
  assign ex_ls_stall        = w_ctrl.ex_ls_stall;
  assign if_id_flush        = w_ctrl.if_id_flush;
  assign id_ex_flush        = w_ctrl.id_ex_flush;
  assign ex_ls_bubble       = w_ctrl.ex_ls_bubble;
  assign ls_wb_bubble       = w_ctrl.ls_wb_bubble;
  assign pc_redirect_valid  = w_rdr_valid;
  assign pc_redirect_target = w_rdr_target;
  assign mem_timeout        = mem_timeout_q;

endmodule

`default_nettype wire
